// File: rtl/uart_pkg.sv
// Shared constants and capture-FSM encoding for the UART receive path.
package uart_pkg;

    localparam int DATA_W     = 8;
    localparam int DEPTH      = 16;
    localparam int BIT_PERIOD = 1250;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACK      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } cap_state_t;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port and one asynchronous read port, no reset.
module fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATA_W-1:0]          rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with a ready/ack capture handshake and first-word-fall-through output.
// Optional sticky overrun flag enabled by defining UART_RX_FIFO_OVERRUN_EN.
module uart_rx_fifo #(
    parameter int DEPTH  = uart_pkg::DEPTH,
    parameter int DATA_W = uart_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ack,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overrun,
    input  logic                     ovr_clr
);

    import uart_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    cap_state_t    state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          capture;
    logic          push;
    logic          pop;
    logic          drop;

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign capture = (state == ST_IDLE) && in_ready;
    assign pop     = out_ack && !empty;
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign out_valid = !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            in_ack <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    in_ack <= 1'b0;
                    if (in_ready) begin
                        in_ack <= 1'b1;
                        state  <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    in_ack <= 1'b0;
                    state  <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    in_ack <= 1'b0;
                    if (!in_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    in_ack <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef UART_RX_FIFO_OVERRUN_EN
    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end
`else
    logic unused_ovr;
    assign unused_ovr = ovr_clr | drop;
    assign overrun    = 1'b0;
`endif

    fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .we      (push),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_addr (rd_ptr),
        .rd_data (out_data)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_ready = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ack;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ack = 1'b0;
    logic [4:0]        count;
    logic              full;
    logic              empty;
    logic              overrun;
    logic              ovr_clr = 1'b0;

    int                n_total = 0;
    int                n_pass  = 0;
    logic [7:0]        q[$];
    bit                ovr_m = 1'b0;

    uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ack    (in_ack),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ack   (out_ack),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"}, 32'(count), q.size());
        check({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
        check({tag, ".overrun"}, 32'(overrun), 32'(ovr_m));
        if (q.size() != 0) begin
            check({tag, ".out_data"}, 32'(out_data), 32'(q[0]));
        end
    endtask

    // Full handshake from IDLE: capture edge, ACK cycle, then release of in_ready.
    task automatic push_byte(input logic [7:0] b, input bit pop, input bit clr);
        bit full_b;
        bit pop_eff;
        full_b  = (q.size() == DEPTH);
        pop_eff = pop && (q.size() != 0);
        in_ready = 1'b1;
        in_data  = b;
        out_ack  = pop;
        ovr_clr  = clr;
        tick();
        if (pop_eff) begin
            void'(q.pop_front());
        end
        if (!full_b || pop_eff) begin
            q.push_back(b);
            if (clr) ovr_m = 1'b0;
        end else begin
`ifdef UART_RX_FIFO_OVERRUN_EN
            ovr_m = 1'b1;
`endif
        end
        check("push.in_ack", 32'(in_ack), 1);
        check_all("push");
        in_ready = 1'b0;
        out_ack  = 1'b0;
        ovr_clr  = 1'b0;
        in_data  = 8'($urandom);
        tick();
        check("push.ack_one_cycle", 32'(in_ack), 0);
        tick();
    endtask

    task automatic pop_byte();
        check("pop.pre_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("pop.pre_data", 32'(out_data), 32'(q[0]));
        end
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        if (q.size() != 0) begin
            void'(q.pop_front());
        end
        check_all("pop");
    endtask

    task automatic clear_ovr();
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        ovr_m   = 1'b0;
        check_all("ovr_clr");
    endtask

    initial begin
        logic [7:0] b;
        int         r;

        rst = 1'b1;
        tick();
        check_all("reset");
        check("reset.in_ack", 32'(in_ack), 0);
        rst = 1'b0;

        push_byte(8'h31, 1'b0, 1'b0);

        // Held ready: one capture only, no re-capture while in_ready stays high.
        in_ready = 1'b1;
        in_data  = 8'h42;
        tick();
        q.push_back(8'h42);
        check("held.in_ack", 32'(in_ack), 1);
        check_all("held");
        in_data = 8'h99;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held.ack_low", 32'(in_ack), 0);
            check("held.count", 32'(count), 2);
        end
        in_ready = 1'b0;
        tick();
        pop_byte();
        pop_byte();

        for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0, 1'b0);
        check("fill.full", 32'(full), 1);
        for (int i = 0; i < 8; i++) pop_byte();
        for (int i = 16; i < 24; i++) push_byte(8'(i), 1'b0, 1'b0);

        push_byte(8'hAA, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_OVERRUN_EN
        check("ovr.set", 32'(overrun), 1);
`else
        check("ovr.tied", 32'(overrun), 0);
`endif
        clear_ovr();
        push_byte(8'hAB, 1'b0, 1'b1);
        clear_ovr();

        push_byte(8'h55, 1'b1, 1'b0);
        check("full_pp.count", 32'(count), 16);
        check("full_pp.head", 32'(out_data), 8'h09);
        while (q.size() != 0) pop_byte();

        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 5);
            b = 8'($urandom);
            case (r)
                0, 1, 2: push_byte(b, 1'b0, ($urandom_range(0, 3) == 0));
                3:       push_byte(b, 1'b1, 1'b0);
                default: pop_byte();
            endcase
            if ($urandom_range(0, 15) == 0) clear_ovr();
        end

        // Reset while the FSM sits in ACK, with the byte still presented.
        in_ready = 1'b1;
        in_data  = 8'hC3;
        tick();
        check("rst_ack.pre", 32'(in_ack), 1);
        rst = 1'b1;
        tick();
        q.delete();
        ovr_m = 1'b0;
        check("rst_ack.in_ack", 32'(in_ack), 0);
        check_all("rst_ack");
        rst = 1'b0;
        tick();
        q.push_back(8'hC3);
        check("rst_ack.recapture", 32'(in_ack), 1);
        check_all("rst_ack.recapture");
        in_ready = 1'b0;
        tick();
        tick();
        pop_byte();

        out_ack = 1'b1;
        tick();
        tick();
        out_ack = 1'b0;
        check_all("empty_pop");
        push_byte(8'h77, 1'b0, 1'b0);
        pop_byte();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, >= 2).
REQ-002 SHALL have parameter DATA_W, default 8, byte width.
REQ-003 SHALL have one clock; reset is synchronous and active-high: clk input 1 (12 MHz system clock); rst input 1 (synchronous reset, active-high).
REQ-004 SHALL have port in_ready, input, 1: receiver holds byte valid until acknowledged.
REQ-005 SHALL have port in_data, input, DATA_W: receiver byte.
REQ-006 SHALL have port in_ack, output, 1: one-cycle acknowledge to the receiver.
REQ-007 SHALL have port out_valid, output, 1: head byte available to the CPU core.
REQ-008 SHALL have port out_data, output, DATA_W: head byte.
REQ-009 SHALL have port out_ack, input, 1: CPU pops the head byte.
REQ-010 SHALL have port count, output, $clog2(DEPTH)+1: current occupancy.
REQ-011 SHALL have port full, output, 1; port empty, output, 1.
REQ-012 SHALL have port overrun, output, 1 (sticky error), and port ovr_clr, input, 1.

Function
REQ-013 SHALL run a capture FSM with states IDLE, ACK and WAIT_LOW.
REQ-014 IDLE: when in_ready=1, SHALL latch in_data into the FIFO (if space), register in_ack=1 and move to ACK.
REQ-015 ACK: in_ack SHALL be 1 for exactly this one cycle, then move to WAIT_LOW.
REQ-016 WAIT_LOW: in_ack=0; SHALL return to IDLE only when in_ready=0, so no byte is captured twice.
REQ-017 SHALL hold in_ack at 0 in every state except ACK.
REQ-018 Output SHALL be first-word-fall-through: out_valid = !empty, and out_data = the oldest entry, combinational from the storage.
REQ-019 A byte captured in IDLE at cycle t SHALL produce out_valid=1 at t+1 when the FIFO was empty.
REQ-020 Pop SHALL occur only when out_ack=1 and out_valid=1; out_ack while empty SHALL be ignored, with no pointer or count change.
REQ-021 Push while full with a simultaneous pop SHALL be accepted; count stays DEPTH.
REQ-022 Push while full with no pop SHALL drop the byte, still complete the ACK handshake, and leave storage unchanged.
REQ-023 Simultaneous push and pop when not full SHALL leave count unchanged.
REQ-024 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-025 full SHALL equal (count==DEPTH); empty SHALL equal (count==0).

Reset
REQ-026 On rst=1, the following SHALL clear at the next clk edge: state=IDLE, pointers=0, count=0, in_ack=0, overrun=0, out_valid=0, full=0, empty=1.
REQ-027 Reset mid-handshake (ACK or WAIT_LOW) SHALL abort to IDLE; a byte still presented (in_ready=1) after reset SHALL be captured as new.
REQ-028 Storage contents SHALL NOT need reset; out_data is don't-care while empty.

Configuration
REQ-029 With macro UART_RX_FIFO_OVERRUN_EN defined, overrun SHALL set on a dropped byte (REQ-022) and hold until ovr_clr=1; if set and clear occur in the same cycle, set SHALL win.
REQ-030 Without UART_RX_FIFO_OVERRUN_EN, overrun SHALL be tied 0, ovr_clr SHALL be ignored, and drop behaviour is otherwise identical.

Structure
REQ-031 Shared package uart_pkg SHALL hold DATA_W, default DEPTH, the BIT_PERIOD constant (1250) and the capture-FSM state encoding.
REQ-032 Storage SHALL be a sub-module fifo_mem: DEPTH x DATA_W, one synchronous write port, one asynchronous read port.
REQ-033 Control logic (FSM, pointers, count, flags) SHALL be implemented in uart_rx_fifo.

Verification
REQ-034 Single byte: after reset, in_ready=1 with in_data=0x31 -> in_ack pulses one cycle at t+1, out_valid=1 and out_data=0x31 at t+1, count=1.
REQ-035 Held ready: in_ready held high for 3 cycles after in_ack -> exactly one entry written, and FSM stays in WAIT_LOW until in_ready=0.
REQ-036 Fill and wrap: push 16 bytes 0x00..0x0F, pop 8, push 8 (0x10..0x17), pop all -> output order 0x00..0x17, and full asserted after the 16th push.
REQ-037 Overrun: with the FIFO full, push 0xAA -> byte dropped, count=16, overrun=1 (macro on) or 0 (macro off); ovr_clr -> overrun=0.
REQ-038 Full with simultaneous push and pop: push 0x55 while out_ack=1 -> count stays 16, old head removed, 0x55 at tail.
REQ-039 Reset in ACK state -> next cycle in_ack=0, count=0, empty=1; and out_ack while empty -> no change.
